// File: rtl/booth_seq_mult_pkg.sv
// rtl/booth_seq_mult_pkg.sv - shared constants, FSM states and precision decode for booth_seq_mult
package booth_seq_mult_pkg;

    localparam int DEF_MAX_PRECISION = 32;
    localparam int CLK_PERIOD        = 10;

    localparam logic [5:0] PREC_4  = 6'd4;
    localparam logic [5:0] PREC_8  = 6'd8;
    localparam logic [5:0] PREC_16 = 6'd16;
    localparam logic [5:0] PREC_32 = 6'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Illegal or oversized encodings fall back to the widest supported width.
    function automatic logic [5:0] eff_precision(input logic [5:0] prec, input logic [5:0] max_prec);
        logic legal;
        legal = (prec == PREC_4) || (prec == PREC_8) || (prec == PREC_16) || (prec == PREC_32);
        if (!legal || (prec > max_prec)) begin
            return max_prec;
        end
        return prec;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// rtl/booth_r4_enc.sv - radix-4 Booth recoder: 3-bit window to {neg, one, two} controls
module booth_r4_enc (
    input  logic [2:0] win,
    output logic       neg,
    output logic       one,
    output logic       two
);

    assign neg = win[2];
    assign one = win[1] ^ win[0];
    assign two = (win[2] & ~win[1] & ~win[0]) | (~win[2] & win[1] & win[0]);

endmodule

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - iterative radix-4 Booth multiplier, 4/8/16/32-bit run-time precision
// Optional early termination on exhausted multiplier bits: define MULT_EARLY_TERM_EN.
module booth_seq_mult
    import booth_seq_mult_pkg::*;
#(
    parameter int MAX_PRECISION  = DEF_MAX_PRECISION,
    parameter bit SIGNED_DEFAULT = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [5:0]                   precision,
    input  logic [MAX_PRECISION-1:0]     jia,
    input  logic [MAX_PRECISION-1:0]     yi,
    input  logic                         valid,
    output logic                         in_ready,
    output logic [2*MAX_PRECISION-1:0]   zi,
    output logic                         ready
);

    localparam int AW = 2 * MAX_PRECISION;
    localparam int YW = MAX_PRECISION + 2;
    localparam int MW = YW + 1;

    state_e          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   mcand_q, mcand_d;
    logic [MW-1:0]   mplier_q, mplier_d;

    logic            accept;
    logic            last_step;
    logic [5:0]      eff_p;
    logic [5:0]      cnt_init;

    logic [6:0]          m_shl, y_shl;
    logic [AW-1:0]       m_raw, m_tmp, m_ext;
    logic signed [AW-1:0] m_shift;
    logic [YW-1:0]       y_raw, y_tmp, y_ext;
    logic signed [YW-1:0] y_shift;

    logic            b_neg, b_one, b_two;
    logic [AW-1:0]   pp_mag, pp;

    assign in_ready = en && (state_q != CALC);
    assign accept   = valid && in_ready;
    assign ready    = (state_q == DONE);
    assign zi       = acc_q;

    assign eff_p    = eff_precision(precision, 6'(MAX_PRECISION));
    assign cnt_init = {1'b0, eff_p[5:1]} + (SIGNED_DEFAULT ? 6'd0 : 6'd1);

    // Truncate to P bits by shifting the operand to the top, then shift back with sign or zero fill.
    always_comb begin
        m_raw   = {{MAX_PRECISION{1'b0}}, jia};
        m_shl   = 7'(AW) - {1'b0, eff_p};
        m_tmp   = m_raw << m_shl;
        m_shift = $signed(m_tmp);
        y_raw   = {2'b00, yi};
        y_shl   = 7'(YW) - {1'b0, eff_p};
        y_tmp   = y_raw << y_shl;
        y_shift = $signed(y_tmp);
        if (SIGNED_DEFAULT) begin
            m_ext = m_shift >>> m_shl;
            y_ext = y_shift >>> y_shl;
        end else begin
            m_ext = m_tmp >> m_shl;
            y_ext = y_tmp >> y_shl;
        end
    end

    booth_r4_enc u_enc (
        .win (mplier_q[2:0]),
        .neg (b_neg),
        .one (b_one),
        .two (b_two)
    );

    always_comb begin
        pp_mag = '0;
        if (b_one) begin
            pp_mag = mcand_q;
        end else if (b_two) begin
            pp_mag = {mcand_q[AW-2:0], 1'b0};
        end
        pp = b_neg ? (~pp_mag + AW'(1)) : pp_mag;
    end

`ifdef MULT_EARLY_TERM_EN
    logic rest_zero, rest_ones;
    assign rest_zero = ~|mplier_q[MW-1:2];
    assign rest_ones = (&mplier_q[MW-1:2]) && SIGNED_DEFAULT;
    assign last_step = (cnt_q == 6'd1) || rest_zero || rest_ones;
`else
    assign last_step = (cnt_q == 6'd1);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (en) begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_d  = CALC;
                        cnt_d    = cnt_init;
                        acc_d    = '0;
                        mcand_d  = m_ext;
                        mplier_d = {y_ext, 1'b0};
                    end
                end
                CALC: begin
                    acc_d    = acc_q + pp;
                    mcand_d  = {mcand_q[AW-3:0], 2'b00};
                    mplier_d = {{2{mplier_q[MW-1]}}, mplier_q[MW-1:2]};
                    cnt_d    = cnt_q - 6'd1;
                    if (last_step) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule
